// File: rtl/core_pkg.sv
// Shared core types: enable flag, data word and per-stage payload structs.
// Pipeline stages size their skid registers from these struct widths.
package core_pkg;

  typedef enum logic {
    DISABLE = 1'b0,
    ENABLE  = 1'b1
  } enable_t;

  typedef logic [31:0] data_t;

  typedef struct packed {
    data_t    result;
    logic [4:0] rd;
    enable_t  wb_en;
  } mem2wb_payload_t;

  localparam int MEM2WB_PAYLOAD_W = $bits(mem2wb_payload_t);

endpackage

// File: rtl/skid_fifo_mem.sv
// DEPTH x PAYLOAD_W register array: async-reset clear, one write port,
// combinational read port.
module skid_fifo_mem #(
  parameter int PAYLOAD_W = 32,
  parameter int DEPTH     = 2,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 wr_en,
  input  logic [PTR_W-1:0]     wr_ptr,
  input  logic [PAYLOAD_W-1:0] wr_data,
  input  logic [PTR_W-1:0]     rd_ptr,
  output logic [PAYLOAD_W-1:0] rd_data
);

  logic [DEPTH-1:0][PAYLOAD_W-1:0] mem;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) mem <= '0;
    else if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and DEPTH-entry skid
// storage; stalls are expressed by dropping out_ready_i.
module pipe_skid_stage
  import core_pkg::*;
#(
  parameter int  PAYLOAD_W = 32,
  parameter int  DEPTH     = 2,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  enable_t              flush_c_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_data_o,
  output logic [PTR_W:0]       count_o
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop, flush;

  // Ready comes only from registered count, so a same-cycle pop never frees a slot.
  assign in_ready_o  = (count < CNT_FULL);
  assign out_valid_o = (count != '0);
  assign count_o     = count;

  assign flush = (flush_c_i == ENABLE);
  assign push  = in_valid_i & in_ready_o;
  assign pop   = out_valid_o & out_ready_i;

  skid_fifo_mem #(
    .PAYLOAD_W (PAYLOAD_W),
    .DEPTH     (DEPTH),
    .PTR_W     (PTR_W)
  ) u_mem (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .wr_en   (push & ~flush),
    .wr_ptr  (wr_ptr),
    .wr_data (in_data_i),
    .rd_ptr  (rd_ptr),
    .rd_data (out_data_o)
  );

  // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  a_count_bound: assert property (@(posedge ACLK) disable iff (ARESET)
    count <= CNT_FULL);
  a_no_push_full: assert property (@(posedge ACLK) disable iff (ARESET)
    push |-> (count != CNT_FULL));
  a_no_pop_empty: assert property (@(posedge ACLK) disable iff (ARESET)
    pop |-> (count != '0));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomized and directed checks of pipe_skid_stage against a queue model.
module tb_pipe_skid_stage;
  import core_pkg::*;

  localparam int W = 32;
  localparam int D = 2;

  logic          ACLK = 1'b0;
  logic          ARESET;
  enable_t       flush_c_i;
  logic          in_valid_i, out_ready_i;
  logic          in_ready_o, out_valid_o;
  logic [W-1:0]  in_data_i, out_data_o;
  logic [1:0]    count_o;

  logic [W-1:0]  mq[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 ACLK = ~ACLK;

  pipe_skid_stage #(.PAYLOAD_W(W), .DEPTH(D)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .flush_c_i   (flush_c_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .count_o     (count_o)
  );

  // Drive one cycle from a negedge, apply the model's rules at the edge,
  // return at the next negedge ready for sampling.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    bit push, pop;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    flush_c_i   = f ? ENABLE : DISABLE;
    push = v && (mq.size() < D);
    pop  = r && (mq.size() != 0);
    @(posedge ACLK);
    if (f) mq.delete();
    else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(d);
    end
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    ARESET = 1'b1; in_valid_i = 0; out_ready_i = 0; in_data_i = '0; flush_c_i = DISABLE;
    repeat (2) @(negedge ACLK);
    n_cmp++; if ({out_valid_o, in_ready_o, count_o} !== 4'b0100) begin n_bad++;
      $display("FAIL reset_flags: got v=%b r=%b c=%0d exp v=0 r=1 c=0", out_valid_o, in_ready_o, count_o); end
    n_cmp++; if (out_data_o !== '0) begin n_bad++;
      $display("FAIL reset_data: got %h exp 0", out_data_o); end
    ARESET = 1'b0;
    mq.delete();
    @(negedge ACLK);
  endtask

  task automatic test_streaming();
    logic [W-1:0] vals[3] = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) begin
      cycle(1, vals[i], 1, 0);
      n_cmp++; if (out_valid_o !== 1'b1 || out_data_o !== vals[i] || count_o !== 2'd1) begin n_bad++;
        $display("FAIL stream_%0d: got v=%b d=%h c=%0d exp v=1 d=%h c=1", i, out_valid_o, out_data_o, count_o, vals[i]); end
    end
    cycle(0, '0, 1, 0);
    n_cmp++; if (out_valid_o !== 1'b0 || count_o !== 2'd0) begin n_bad++;
      $display("FAIL stream_drain: got v=%b c=%0d exp v=0 c=0", out_valid_o, count_o); end
  endtask

  task automatic test_backpressure();
    cycle(1, 32'hA, 0, 0);
    cycle(1, 32'hB, 0, 0);
    n_cmp++; if (count_o !== 2'd2 || in_ready_o !== 1'b0 || out_data_o !== 32'hA) begin n_bad++;
      $display("FAIL bp_full: got c=%0d r=%b d=%h exp c=2 r=0 d=a", count_o, in_ready_o, out_data_o); end
    cycle(1, 32'hC, 0, 0);
    n_cmp++; if (count_o !== 2'd2 || out_data_o !== 32'hA || out_valid_o !== 1'b1) begin n_bad++;
      $display("FAIL bp_hold: got c=%0d d=%h v=%b exp c=2 d=a v=1", count_o, out_data_o, out_valid_o); end
    cycle(0, '0, 1, 0);
    n_cmp++; if (count_o !== 2'd1 || out_data_o !== 32'hB) begin n_bad++;
      $display("FAIL bp_pop_a: got c=%0d d=%h exp c=1 d=b", count_o, out_data_o); end
    cycle(1, 32'hC, 1, 0);
    n_cmp++; if (count_o !== 2'd1 || out_data_o !== 32'hC) begin n_bad++;
      $display("FAIL bp_reoffer_c: got c=%0d d=%h exp c=1 d=c", count_o, out_data_o); end
    cycle(0, '0, 1, 0);
  endtask

  task automatic test_full_pop();
    cycle(1, 32'h1, 0, 0);
    cycle(1, 32'h2, 0, 0);
    cycle(1, 32'hD, 1, 0);
    n_cmp++; if (count_o !== 2'd1 || out_data_o !== 32'h2) begin n_bad++;
      $display("FAIL fullpop_count: got c=%0d d=%h exp c=1 d=2", count_o, out_data_o); end
    cycle(0, '0, 1, 0);
    n_cmp++; if (count_o !== 2'd0 || out_valid_o !== 1'b0) begin n_bad++;
      $display("FAIL fullpop_no_d: got c=%0d v=%b exp c=0 v=0", count_o, out_valid_o); end
  endtask

  task automatic test_flush();
    cycle(1, 32'h7, 0, 0);
    cycle(1, 32'h8, 0, 0);
    cycle(1, 32'hE, 1, 1);
    n_cmp++; if (count_o !== 2'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin n_bad++;
      $display("FAIL flush_empty: got c=%0d v=%b r=%b exp c=0 v=0 r=1", count_o, out_valid_o, in_ready_o); end
    cycle(1, 32'h55, 0, 0);
    n_cmp++; if (count_o !== 2'd1 || out_data_o !== 32'h55) begin n_bad++;
      $display("FAIL flush_after: got c=%0d d=%h exp c=1 d=55", count_o, out_data_o); end
    cycle(0, '0, 1, 0);
  endtask

  task automatic test_wrap_random();
    for (int i = 0; i < 40; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, 0);
      n_cmp++;
      if (out_valid_o !== (mq.size() != 0) || count_o !== 2'(mq.size()) ||
          in_ready_o !== (mq.size() < D) || (mq.size() != 0 && out_data_o !== mq[0])) begin
        n_bad++;
        $display("FAIL wrap_%0d: got v=%b c=%0d r=%b d=%h exp c=%0d d=%h", i, out_valid_o, count_o,
                 in_ready_o, out_data_o, mq.size(), (mq.size() != 0) ? mq[0] : '0);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 32'h99, 0, 0);
    cycle(1, 32'h9A, 0, 0);
    ARESET = 1'b1;
    #1;
    n_cmp++; if ({out_valid_o, in_ready_o, count_o} !== 4'b0100 || out_data_o !== '0) begin n_bad++;
      $display("FAIL reset_mid: got v=%b r=%b c=%0d d=%h exp v=0 r=1 c=0 d=0", out_valid_o, in_ready_o, count_o, out_data_o); end
    mq.delete();
    @(negedge ACLK);
    ARESET = 1'b0;
    in_valid_i = 0;
    @(negedge ACLK);
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_pop();
        test_flush();
        test_wrap_random();
        test_reset_mid();
      end
      begin
        repeat (2000) @(posedge ACLK);
        n_bad++;
        $display("FAIL timeout: got no completion exp completion within 2000 cycles");
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
